// File: rtl/lcd_frame_scheduler.sv
// PCD8544 (Nokia 5110) sequencer: hardware reset pulse, init command list, then 504-byte frames
// read from a synchronous framebuffer RAM, each byte in a 17*CLK_DIV slot (16 half-periods + gap).
module lcd_frame_scheduler #(
   parameter int         CLK_DIV    = 4,
   parameter int         RST_CYCLES = 16,
   parameter logic [7:0] VOP        = 8'hB1
) (
   input  logic       clock,
   input  logic       Reset,
   input  logic       frame_req,
   input  logic [7:0] fb_data,
   output logic [8:0] fb_addr,
   output logic       mosi,
   output logic       sclk,
   output logic       sce,
   output logic       dc,
   output logic       lcd_rst_n,
   output logic [7:0] message,
   output logic       busy,
   output logic       frame_done
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int RC_W  = (RST_CYCLES > 0) ? $clog2(RST_CYCLES + 1) : 1;

   typedef enum logic [2:0] {LCD_RST, INIT, IDLE, ADDR, DATA} state_t;

   state_t            state, state_nx;
   logic [8:0]        idx, idx_nx;
   logic [RC_W-1:0]   rst_cnt, rst_cnt_nx;
   logic              lcd_rst_nx;
   logic [8:0]        addr_nx;
   logic              done_nx;
   logic              pend, clr_req;
   logic              start;
   logic [7:0]        start_byte;
   logic              start_dc;
   logic              active;
   logic [4:0]        half;
   logic [DIV_W-1:0]  div_cnt;
   logic [7:0]        shreg;
   logic              slot_end;

   assign busy     = (state != IDLE);
   assign slot_end = active && (half == 5'd16) && (div_cnt == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         state      <= LCD_RST;
         idx        <= '0;
         rst_cnt    <= '0;
         lcd_rst_n  <= 1'b0;
         fb_addr    <= '0;
         frame_done <= 1'b0;
         pend       <= 1'b0;
      end else begin
         state      <= state_nx;
         idx        <= idx_nx;
         rst_cnt    <= rst_cnt_nx;
         lcd_rst_n  <= lcd_rst_nx;
         fb_addr    <= addr_nx;
         frame_done <= done_nx;
         pend       <= clr_req ? 1'b0 : (pend | frame_req);
      end
   end

   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      rst_cnt_nx = rst_cnt;
      lcd_rst_nx = lcd_rst_n;
      addr_nx    = fb_addr;
      done_nx    = 1'b0;
      clr_req    = 1'b0;
      start      = 1'b0;
      case (state)
         LCD_RST: begin
            if (rst_cnt == RC_W'(RST_CYCLES)) begin
               lcd_rst_nx = 1'b1;
               state_nx   = INIT;
            end else begin
               rst_cnt_nx = rst_cnt + 1'b1;
            end
         end
         INIT: begin
            if (!active) begin
               start = 1'b1;
            end else if (slot_end) begin
               if (idx == 9'd5) begin
                  state_nx = IDLE;
                  idx_nx   = '0;
               end else begin
                  idx_nx = idx + 9'd1;
                  start  = 1'b1;
               end
            end
         end
         IDLE: begin
            if (pend || frame_req) begin
               state_nx = ADDR;
               idx_nx   = '0;
               start    = 1'b1;
               clr_req  = 1'b1;
            end
         end
         ADDR: begin
            if (slot_end) begin
               start = 1'b1;
               if (idx == 9'd1) begin
                  state_nx = DATA;
                  idx_nx   = '0;
                  addr_nx  = 9'd1;
               end else begin
                  idx_nx = idx + 9'd1;
               end
            end
         end
         DATA: begin
            if (slot_end) begin
               if (idx == 9'd503) begin
                  state_nx = IDLE;
                  idx_nx   = '0;
                  addr_nx  = '0;
                  done_nx  = 1'b1;
               end else begin
                  idx_nx  = idx + 9'd1;
                  start   = 1'b1;
                  // prefetch the following byte a full slot ahead; the last byte keeps its address
                  addr_nx = (idx_nx == 9'd503) ? 9'd503 : idx_nx + 9'd1;
               end
            end
         end
         default: state_nx = LCD_RST;
      endcase

      start_byte = fb_data;
      start_dc   = 1'b0;
      case (state_nx)
         INIT: begin
            case (idx_nx[2:0])
               3'd0:    start_byte = 8'h21;
               3'd1:    start_byte = VOP;
               3'd2:    start_byte = 8'h04;
               3'd3:    start_byte = 8'h14;
               3'd4:    start_byte = 8'h20;
               default: start_byte = 8'h0C;
            endcase
         end
         ADDR:    start_byte = (idx_nx == 9'd0) ? 8'h80 : 8'h40;
         DATA:    start_dc = 1'b1;
         default: start_dc = 1'b0;
      endcase
   end

   // byte engine: half 0..15 alternate sclk low/high with sce low, half 16 is the sce-high gap
   always_ff @(posedge clock or negedge Reset) begin
      if (!Reset) begin
         active  <= 1'b0;
         half    <= '0;
         div_cnt <= '0;
         shreg   <= '0;
         sce     <= 1'b1;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         dc      <= 1'b0;
         message <= '0;
      end else if (start) begin
         active  <= 1'b1;
         half    <= '0;
         div_cnt <= '0;
         sce     <= 1'b0;
         sclk    <= 1'b0;
         mosi    <= start_byte[7];
         shreg   <= {start_byte[6:0], 1'b0};
         message <= start_byte;
         dc      <= start_dc;
      end else if (active) begin
         if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            if (half == 5'd16) begin
               active <= 1'b0;
            end else begin
               half <= half + 5'd1;
               if (!half[0]) begin
                  sclk <= 1'b1;
               end else begin
                  sclk <= 1'b0;
                  if (half == 5'd15) begin
                     sce <= 1'b1;
                  end else begin
                     mosi  <= shreg[7];
                     shreg <= {shreg[6:0], 1'b0};
                  end
               end
            end
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end
endmodule
